// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Produces the single clean, synchronous, active-high SoC reset. It
//   stretches power-on reset, and it synchronizes and debounces the
//   active-low reset button. While the button is held, and for a fixed hold
//   after it is released, the SoC is kept in reset. A press pulse and a
//   saturating press counter are also provided for LEDs and debug.
//
// Ports
//   clk_48mhz      in   system clock; all logic runs on its rising edge
//   reset          in   synchronous active-high power-on pulse
//   button_n       in   raw asynchronous button; low means pressed
//   soc_reset      out  registered active-high reset to the SoC
//   button_pressed out  one-cycle pulse for each debounced press taken in RUN
//   press_count    out  number of accepted presses, saturating at 255
//   state_dbg      out  current FSM state encoding
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int HOLD_CYCLES     = 4800
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       button_n,
  output logic       soc_reset,
  output logic       button_pressed,
  output logic [7:0] press_count,
  output logic [1:0] state_dbg
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    POR_HOLD     = 2'd0,
    RUN          = 2'd1,
    BTN_HELD     = 2'd2,
    RELEASE_HOLD = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic                   stable_prev_q, stable_prev_d;
  logic [DB_W-1:0]        debounce_cnt_q, debounce_cnt_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  state_e                 state_q, state_d;
  logic                   soc_reset_q, soc_reset_d;
  logic                   button_pressed_q, button_pressed_d;
  logic [7:0]             press_count_q, press_count_d;

  logic sync_out;
  logic stable_fell;
  logic stable_rose;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronizer chain plus debounce. The debounced level only flips after
  // DEBOUNCE_CYCLES consecutive synchronized samples disagree with it.
  always_comb begin
    sync_d         = {sync_q[SYNC_STAGES-2:0], button_n};
    stable_d       = stable_q;
    debounce_cnt_d = '0;
    if (sync_out != stable_q) begin
      if (debounce_cnt_q == DB_LAST) begin
        stable_d = sync_out;
      end else begin
        debounce_cnt_d = debounce_cnt_q + 1'b1;
      end
    end
    stable_prev_d = stable_q;
  end

  // Edges come from a delayed copy of the debounced level, so the FSM
  // reacts one cycle after stable changes.
  assign stable_fell = stable_prev_q & ~stable_q;
  assign stable_rose = ~stable_prev_q & stable_q;

  always_comb begin
    state_d          = state_q;
    hold_cnt_d       = hold_cnt_q;
    button_pressed_d = 1'b0;
    press_count_d    = press_count_q;
    case (state_q)
      POR_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (stable_fell) begin
          state_d          = BTN_HELD;
          button_pressed_d = 1'b1;
          if (press_count_q != 8'hFF) begin
            press_count_d = press_count_q + 8'd1;
          end
        end
      end
      BTN_HELD: begin
        if (stable_rose) begin
          state_d    = RELEASE_HOLD;
          hold_cnt_d = '0;
        end
      end
      RELEASE_HOLD: begin
        // A new press during the release hold goes straight back to held
        // without counting, since the SoC never left reset.
        if (stable_fell) begin
          state_d    = BTN_HELD;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = POR_HOLD;
        hold_cnt_d = '0;
      end
    endcase
    soc_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      sync_q           <= '1;
      stable_q         <= 1'b1;
      stable_prev_q    <= 1'b1;
      debounce_cnt_q   <= '0;
      hold_cnt_q       <= '0;
      state_q          <= POR_HOLD;
      soc_reset_q      <= 1'b1;
      button_pressed_q <= 1'b0;
      press_count_q    <= '0;
    end else begin
      sync_q           <= sync_d;
      stable_q         <= stable_d;
      stable_prev_q    <= stable_prev_d;
      debounce_cnt_q   <= debounce_cnt_d;
      hold_cnt_q       <= hold_cnt_d;
      state_q          <= state_d;
      soc_reset_q      <= soc_reset_d;
      button_pressed_q <= button_pressed_d;
      press_count_q    <= press_count_d;
    end
  end

  assign soc_reset      = soc_reset_q;
  assign button_pressed = button_pressed_q;
  assign press_count    = press_count_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. Two instances share clock, reset and button:
// u_dut has the standard short hold, and u_dut_lh has a long hold. With an
// 8-cycle debounce needed in each direction, a clean re-press can never
// land inside a 4-cycle release hold. The long-hold instance is therefore
// the one used to reach the RELEASE_HOLD -> BTN_HELD path.
module tb_reset_sequencer;

  localparam int SYNC   = 2;
  localparam int DEB    = 8;
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 16;

  logic clk;
  logic reset;
  logic button_n;

  logic       soc_a, pulse_a, soc_b, pulse_b;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] st_a, st_b;

  reset_sequencer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD_A)) u_dut (
    .clk_48mhz      (clk),
    .reset          (reset),
    .button_n       (button_n),
    .soc_reset      (soc_a),
    .button_pressed (pulse_a),
    .press_count    (cnt_a),
    .state_dbg      (st_a)
  );

  reset_sequencer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD_B)) u_dut_lh (
    .clk_48mhz      (clk),
    .reset          (reset),
    .button_n       (button_n),
    .soc_reset      (soc_b),
    .button_pressed (pulse_b),
    .press_count    (cnt_b),
    .state_dbg      (st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. The button is delayed by a queue, and the debounced
  // level flips when the last DEB delayed samples all disagree with it. Each
  // FSM works on events, with a countdown of the remaining hold cycles.
  bit m_syncq[$];
  bit m_win[$];
  bit m_stable;
  bit m_stable_old;
  int m_state[2];
  int m_hold_left[2];
  int m_count[2];
  bit m_pulse[2];

  function automatic int hold_of(input int k);
    return (k == 0) ? HOLD_A : HOLD_B;
  endfunction

  task automatic model_step(input bit rst, input bit btn);
    bit s;
    bit flip;
    bit fell;
    bit rose;
    if (rst) begin
      m_syncq.delete();
      repeat (SYNC) m_syncq.push_back(1'b1);
      m_win.delete();
      m_stable     = 1'b1;
      m_stable_old = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_state[k]     = 0;
        m_hold_left[k] = hold_of(k);
        m_count[k]     = 0;
        m_pulse[k]     = 1'b0;
      end
      return;
    end
    fell = m_stable_old && !m_stable;
    rose = !m_stable_old && m_stable;
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 1'b0;
      case (m_state[k])
        0: begin
          m_hold_left[k]--;
          if (m_hold_left[k] == 0) m_state[k] = 1;
        end
        1: if (fell) begin
          m_state[k] = 2;
          m_pulse[k] = 1'b1;
          if (m_count[k] < 255) m_count[k]++;
        end
        2: if (rose) begin
          m_state[k]     = 3;
          m_hold_left[k] = hold_of(k);
        end
        default: begin
          if (fell) m_state[k] = 2;
          else begin
            m_hold_left[k]--;
            if (m_hold_left[k] == 0) m_state[k] = 1;
          end
        end
      endcase
    end
    s = m_syncq.pop_front();
    m_syncq.push_back(btn);
    m_win.push_back(s);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    flip = (m_win.size() == DEB);
    foreach (m_win[i]) if (m_win[i] == m_stable) flip = 1'b0;
    m_stable_old = m_stable;
    if (flip) m_stable = !m_stable;
  endtask

  always @(posedge clk) model_step(reset, button_n);

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("soc_a",   soc_a,   (m_state[0] != 1));
      check_eq("pulse_a", pulse_a, m_pulse[0]);
      check_eq("cnt_a",   cnt_a,   m_count[0]);
      check_eq("state_a", st_a,    m_state[0]);
      check_eq("soc_b",   soc_b,   (m_state[1] != 1));
      check_eq("pulse_b", pulse_b, m_pulse[1]);
      check_eq("cnt_b",   cnt_b,   m_count[1]);
      check_eq("state_b", st_b,    m_state[1]);
    end
  end

  int pulses_a;
  int pulses_b;
  int soc_a_hi;
  int soc_b_low;
  int run_a;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (pulse_a) pulses_a++;
      if (pulse_b) pulses_b++;
      if (soc_a) soc_a_hi++;
      if (!soc_b) soc_b_low++;
      if (st_a == 2'd1) run_a++;
    end
  endtask

  task automatic wait_soc_a(input logic lvl, output int cyc);
    cyc = 0;
    do begin
      tick(1);
      cyc++;
    end while (soc_a !== lvl && cyc < 200);
  endtask

  task automatic wait_state(input int inst, input logic [1:0] s, output int cyc);
    cyc = 0;
    do begin
      tick(1);
      cyc++;
    end while (((inst == 0) ? st_a : st_b) !== s && cyc < 200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset    = 1'b1;
    button_n = 1'b1;
    pulses_a = 0; pulses_b = 0; soc_a_hi = 0; soc_b_low = 0; run_a = 0;

    // Power-on reset: three reset cycles, then the hold stretch.
    @(negedge clk);
    chk_en = 1'b1;
    tick(2);
    check_eq("rst_soc",   soc_a,   1);
    check_eq("rst_pulse", pulse_a, 0);
    check_eq("rst_cnt",   cnt_a,   0);
    check_eq("rst_state", st_a,    0);
    reset = 1'b0;
    wait_soc_a(1'b0, c);
    check_eq("por_len",   c,    HOLD_A);
    check_eq("por_state", st_a, 1);
    check_eq("por_cnt",   cnt_a, 0);
    tick(20);

    // A short bounce is filtered out.
    pulses_a = 0; soc_a_hi = 0;
    button_n = 1'b0;
    tick(5);
    button_n = 1'b1;
    tick(20);
    check_eq("bounce_pulse", pulses_a, 0);
    check_eq("bounce_soc",   soc_a_hi, 0);
    check_eq("bounce_cnt",   cnt_a,    0);

    // A clean press held for 30 cycles, then released.
    pulses_a = 0;
    button_n = 1'b0;
    wait_soc_a(1'b1, c);
    check_eq("press_lat", c, SYNC + DEB + 1);
    tick(30 - c);
    check_eq("press_pulses", pulses_a, 1);
    check_eq("press_cnt",    cnt_a,    1);
    check_eq("press_state",  st_a,     2);
    button_n = 1'b1;
    wait_soc_a(1'b0, c);
    check_eq("release_lat",   c,    SYNC + DEB + 1 + HOLD_A);
    check_eq("release_state", st_a, 1);
    tick(20);

    // Re-press during the release hold of the long-hold instance.
    button_n = 1'b0;
    tick(30);
    button_n = 1'b1;
    wait_state(1, 2'd3, c);
    check_eq("lh_rel_enter", c, SYNC + DEB + 1);
    pulses_b = 0; soc_b_low = 0;
    tick(1);
    button_n = 1'b0;
    tick(30);
    check_eq("repress_pulse", pulses_b,  0);
    check_eq("repress_soc",   soc_b_low, 0);
    check_eq("repress_cnt",   cnt_b,     2);
    check_eq("repress_state", st_b,      2);
    check_eq("repress_cnt_a", cnt_a,     3);
    button_n = 1'b1;
    tick(40);

    // Saturation of the press counter.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
    pulses_a = 0;
    for (int i = 1; i <= 300; i++) begin
      button_n = 1'b0;
      tick(12);
      button_n = 1'b1;
      tick(20);
      if (i == 100) check_eq("sat_cnt100", cnt_a, 100);
      if (i == 255) check_eq("sat_cnt255", cnt_a, 255);
    end
    check_eq("sat_cnt_end", cnt_a,    255);
    check_eq("sat_pulses",  pulses_a, 300);

    // Reset while the button is held down.
    button_n = 1'b0;
    wait_state(0, 2'd2, c);
    check_eq("held_reach", st_a, 2);
    reset = 1'b1;
    tick(1);
    check_eq("held_rst_cnt",   cnt_a,   0);
    check_eq("held_rst_state", st_a,    0);
    check_eq("held_rst_soc",   soc_a,   1);
    check_eq("held_rst_pulse", pulse_a, 0);
    reset = 1'b0;
    run_a = 0; pulses_a = 0;
    tick(20);
    check_eq("held_run_len", run_a,    7);
    check_eq("held_pulses",  pulses_a, 1);
    check_eq("held_cnt",     cnt_a,    1);
    check_eq("held_state",   st_a,     2);
    button_n = 1'b1;
    tick(40);

    // Random button activity, with occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
      button_n = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 40));
    end
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
